// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply stream sequencer: sequencer states,
// parameter defaults, header field positions and the dimension legality check.
package mm_pkg;

   localparam int DEF_N          = 4;
   localparam int DEF_IDX_W      = 4;
   localparam int DEF_DATA_WIDTH = 8;

   localparam int ROWS_HI = 7;
   localparam int ROWS_LO = 4;
   localparam int COLS_HI = 3;
   localparam int COLS_LO = 0;

   typedef enum logic [3:0] {
      HDR_A,
      LOAD_A,
      HDR_B,
      LOAD_B,
      CHECK,
      ISSUE,
      WAIT,
      OUT,
      ERR
   } state_t;

   function automatic logic dim_ok(input int unsigned d, input int unsigned n);
      return (d != 0) && (d <= n);
   endfunction

endpackage

// File: rtl/mm_idx_counter.sv
// Row/column index counter that walks a rows x cols grid in row-major order;
// wrap flags the final element of the grid.
module mm_idx_counter #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             step,
   input  logic [IDX_W-1:0] rows,
   input  logic [IDX_W-1:0] cols,
   output logic [IDX_W-1:0] row,
   output logic [IDX_W-1:0] col,
   output logic             wrap
);

   localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

   logic col_end;

   assign col_end = (col == cols - ONE);
   assign wrap    = col_end && (row == rows - ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (step) begin
         if (col_end) begin
            col <= '0;
            row <= row + ONE;
         end else begin
            col <= col + ONE;
         end
      end
   end

endmodule

// File: rtl/mm_stream_ctrl.sv
// Upstream sequencer for the matrix-multiply helper: loads A and B from a byte
// stream, checks dimensions, sweeps compute requests and streams C row-major.
module mm_stream_ctrl
   import mm_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int N              = DEF_N,
   parameter int IDX_W          = DEF_IDX_W,
   parameter int OUT_DATA_WIDTH = 20
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_DATA_WIDTH-1:0] out_data,
   output logic                      out_last,
   output logic                      err,
   output logic                      hw_wr_enable,
   output logic                      hw_compute_enable,
   output logic [DATA_WIDTH-1:0]     hw_in_data,
   output logic [IDX_W-1:0]          hw_i,
   output logic [IDX_W-1:0]          hw_j,
   output logic                      hw_is_first_mat,
   output logic [IDX_W-1:0]          hw_match_dim,
   input  logic [OUT_DATA_WIDTH-1:0] hw_out_data
);

   state_t state, state_nx;

   logic [IDX_W-1:0] rows_a, cols_a, rows_b, cols_b;
   logic [IDX_W-1:0] hdr_rows, hdr_cols;
   logic             hdr_ok, hs, first_q;

   logic             ld_clear, ld_step, ld_wrap;
   logic [IDX_W-1:0] ld_rows, ld_cols, ld_row, ld_col;
   logic             sw_clear, sw_step, sw_wrap;
   logic [IDX_W-1:0] sw_row, sw_col;

   assign hs           = in_valid && in_ready;
   assign hdr_rows     = IDX_W'(in_data[ROWS_HI:ROWS_LO]);
   assign hdr_cols     = IDX_W'(in_data[COLS_HI:COLS_LO]);
   assign hdr_ok       = dim_ok(32'(hdr_rows), N) && dim_ok(32'(hdr_cols), N);
   assign hw_in_data   = in_data;
   assign hw_match_dim = cols_a;

   mm_idx_counter #(.IDX_W(IDX_W)) u_load_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (ld_clear),
      .step  (ld_step),
      .rows  (ld_rows),
      .cols  (ld_cols),
      .row   (ld_row),
      .col   (ld_col),
      .wrap  (ld_wrap)
   );

   mm_idx_counter #(.IDX_W(IDX_W)) u_sweep_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (sw_clear),
      .step  (sw_step),
      .rows  (rows_a),
      .cols  (cols_b),
      .row   (sw_row),
      .col   (sw_col),
      .wrap  (sw_wrap)
   );

   always_comb begin
      state_nx          = state;
      in_ready          = 1'b0;
      out_valid         = 1'b0;
      err               = 1'b0;
      hw_wr_enable      = 1'b0;
      hw_compute_enable = 1'b0;
      hw_is_first_mat   = first_q;
      hw_i              = sw_row;
      hw_j              = sw_col;
      ld_clear          = 1'b0;
      ld_step           = 1'b0;
      ld_rows           = rows_b;
      ld_cols           = cols_b;
      sw_clear          = 1'b0;
      sw_step           = 1'b0;
      case (state)
         HDR_A, HDR_B: begin
            in_ready = 1'b1;
            ld_clear = 1'b1;
            if (hs) begin
               if (!hdr_ok)
                  state_nx = ERR;
               else
                  state_nx = (state == HDR_A) ? LOAD_A : LOAD_B;
            end
         end
         LOAD_A, LOAD_B: begin
            in_ready        = 1'b1;
            hw_wr_enable    = hs;
            ld_step         = hs;
            hw_i            = ld_row;
            hw_j            = ld_col;
            hw_is_first_mat = (state == LOAD_A);
            if (state == LOAD_A) begin
               ld_rows = rows_a;
               ld_cols = cols_a;
            end
            if (hs && ld_wrap)
               state_nx = (state == LOAD_A) ? HDR_B : CHECK;
         end
         CHECK: begin
            sw_clear = 1'b1;
            state_nx = (cols_a == rows_b) ? ISSUE : ERR;
         end
         ISSUE: begin
            hw_compute_enable = 1'b1;
            state_nx          = WAIT;
         end
         WAIT: state_nx = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (out_last) begin
                  state_nx = HDR_A;
               end else begin
                  sw_step  = 1'b1;
                  state_nx = ISSUE;
               end
            end
         end
         ERR: begin
            err      = 1'b1;
            state_nx = HDR_A;
         end
         default: state_nx = HDR_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= HDR_A;
         rows_a   <= '0;
         cols_a   <= '0;
         rows_b   <= '0;
         cols_b   <= '0;
         first_q  <= 1'b1;
         out_data <= '0;
         out_last <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == HDR_A && hs) begin
            rows_a <= hdr_rows;
            cols_a <= hdr_cols;
         end
         if (state == HDR_B && hs) begin
            rows_b <= hdr_rows;
            cols_b <= hdr_cols;
         end
         if (state == LOAD_A)
            first_q <= 1'b1;
         else if (state == LOAD_B)
            first_q <= 1'b0;
         // helper result is registered, so it is valid in WAIT, one cycle after ISSUE
         if (state == WAIT) begin
            out_data <= hw_out_data;
            out_last <= sw_wrap;
         end else if (state == OUT && out_ready) begin
            out_last <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mm_stream_ctrl.sv
// Bench for mm_stream_ctrl: behavioural helper beside the DUT, matrix-product
// reference model, randomized jobs and directed corner scenarios.
module tb_mm_stream_ctrl;

   localparam int DW = 8;
   localparam int NN = 4;
   localparam int IW = 4;
   localparam int OW = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, out_last, err;
   logic [OW-1:0] out_data;
   logic          hw_wr_enable, hw_compute_enable, hw_is_first_mat;
   logic [DW-1:0] hw_in_data;
   logic [IW-1:0] hw_i, hw_j, hw_match_dim;
   logic [OW-1:0] hw_out_data = '0;

   int errors = 0;
   int checks = 0;

   int err_cnt = 0, ov_cnt = 0, wr_cnt = 0, overlap_cnt = 0;

   int ma [4][4];
   int mb [4][4];

   logic [OW-1:0] obs_d[$];
   logic          obs_l[$];
   int            unstable;
   int            first_lat;
   bit            timed_out;

   logic signed [7:0] ha [4][4] = '{default: '0};
   logic signed [7:0] hb [4][4] = '{default: '0};

   always #5 clk = ~clk;

   mm_stream_ctrl #(
      .DATA_WIDTH(DW), .N(NN), .IDX_W(IW), .OUT_DATA_WIDTH(OW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .err(err),
      .hw_wr_enable(hw_wr_enable), .hw_compute_enable(hw_compute_enable),
      .hw_in_data(hw_in_data), .hw_i(hw_i), .hw_j(hw_j),
      .hw_is_first_mat(hw_is_first_mat), .hw_match_dim(hw_match_dim),
      .hw_out_data(hw_out_data)
   );

   // Behavioural helper: persistent A/B storage and a registered dot product.
   function automatic logic [OW-1:0] helper_dot(input logic [IW-1:0] i, input logic [IW-1:0] j,
                                                input logic [IW-1:0] k);
      int s = 0;
      for (int m = 0; m < int'(k) && m < 4; m++)
         s += int'(ha[i[1:0]][m]) * int'(hb[m][j[1:0]]);
      return OW'(s);
   endfunction

   always @(posedge clk) begin
      if (hw_wr_enable) begin
         if (hw_is_first_mat) ha[hw_i[1:0]][hw_j[1:0]] <= hw_in_data;
         else                 hb[hw_i[1:0]][hw_j[1:0]] <= hw_in_data;
      end
      if (hw_compute_enable)
         hw_out_data <= helper_dot(hw_i, hw_j, hw_match_dim);
   end

   always @(negedge clk) begin
      if (err === 1'b1) err_cnt++;
      if (out_valid === 1'b1) ov_cnt++;
      if (hw_wr_enable === 1'b1) wr_cnt++;
      if (hw_wr_enable === 1'b1 && hw_compute_enable === 1'b1) overlap_cnt++;
   end

   function automatic logic [OW-1:0] ref_elem(input int i, input int j, input int k);
      int s = 0;
      for (int m = 0; m < k; m++) s += ma[i][m] * mb[m][j];
      return OW'(s);
   endfunction

   function automatic int rnd_byte();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int w = 0;
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (in_ready !== 1'b1) timed_out = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_job(input int ra, input int ca, input int rb, input int cb,
                          input int stall_min, input int stall_max, input bit gaps);
      obs_d.delete();
      obs_l.delete();
      unstable  = 0;
      first_lat = -1;
      timed_out = 1'b0;
      send_byte(8'(ra * 16 + ca), gaps);
      for (int r = 0; r < ra; r++)
         for (int c = 0; c < ca; c++) send_byte(8'(ma[r][c]), gaps);
      send_byte(8'(rb * 16 + cb), gaps);
      for (int r = 0; r < rb; r++)
         for (int c = 0; c < cb; c++) send_byte(8'(mb[r][c]), gaps);
      if (ca == rb) begin
         for (int n = 0; n < ra * cb; n++) begin
            int            w = 0;
            int            stall;
            logic [OW-1:0] d;
            logic          l;
            while (out_valid !== 1'b1 && w < 50) begin
               @(negedge clk);
               w++;
            end
            if (out_valid !== 1'b1) begin
               timed_out = 1'b1;
               break;
            end
            if (n == 0) first_lat = w;
            d = out_data;
            l = out_last;
            stall = int'($urandom_range(stall_min, stall_max));
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               if (out_valid !== 1'b1 || out_data !== d || out_last !== l) unstable++;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            obs_d.push_back(d);
            obs_l.push_back(l);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
      checks++; if (hw_wr_enable !== 1'b0 || hw_compute_enable !== 1'b0) begin
         errors++; $display("FAIL reset_strobes got=%b%b want=00", hw_wr_enable, hw_compute_enable); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
      checks++; if (hw_i !== '0 || hw_j !== '0) begin errors++; $display("FAIL reset_idx got=%0d,%0d want=0,0", hw_i, hw_j); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int exp_d [4] = '{19, 22, 43, 50};
      int wr0, err0;
      ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
      mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
      #1; wr0 = wr_cnt; err0 = err_cnt;
      @(negedge clk);
      run_job(2, 2, 2, 2, 0, 0, 1'b0);
      #1;
      checks++; if (timed_out !== 1'b0 || obs_d.size() != 4) begin
         errors++; $display("FAIL basic_count got=%0d timeout=%b want=4", obs_d.size(), timed_out); end
      for (int n = 0; n < obs_d.size() && n < 4; n++) begin
         checks++; if (obs_d[n] !== OW'(exp_d[n]) || obs_l[n] !== (n == 3)) begin
            errors++; $display("FAIL basic_elem%0d got=%0d/last%b want=%0d/last%b", n,
                               $signed(obs_d[n]), obs_l[n], exp_d[n], n == 3); end
      end
      checks++; if (first_lat != 3) begin errors++; $display("FAIL basic_latency got=%0d want=3", first_lat); end
      checks++; if (wr_cnt - wr0 != 8) begin errors++; $display("FAIL basic_writes got=%0d want=8", wr_cnt - wr0); end
      checks++; if (err_cnt != err0) begin errors++; $display("FAIL basic_err got=%0d want=0", err_cnt - err0); end
   endtask

   task automatic test_backpressure();
      ma[0][0] = 1; ma[0][1] = -2; ma[0][2] = 3;
      mb[0][0] = 4; mb[1][0] = 5; mb[2][0] = 6;
      run_job(1, 3, 3, 1, 5, 5, 1'b0);
      checks++; if (obs_d.size() != 1 || timed_out) begin
         errors++; $display("FAIL bp_count got=%0d timeout=%b want=1", obs_d.size(), timed_out); end
      else begin
         checks++; if (obs_d[0] !== OW'(12) || obs_l[0] !== 1'b1) begin
            errors++; $display("FAIL bp_data got=%0d/last%b want=12/last1", $signed(obs_d[0]), obs_l[0]); end
      end
      checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got=%0d unstable cycles want=0", unstable); end
   endtask

   task automatic test_mismatch();
      int err0, ov0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin ma[r][c] = rnd_byte(); mb[r][c] = rnd_byte(); end
      #1; err0 = err_cnt; ov0 = ov_cnt;
      @(negedge clk);
      run_job(2, 3, 2, 2, 0, 0, 1'b0);
      @(negedge clk);
      checks++; if (err !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL mismatch_err got=err%b rdy%b want=err1 rdy0", err, in_ready); end
      @(negedge clk);
      checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL mismatch_recover got=err%b rdy%b want=err0 rdy1", err, in_ready); end
      #1;
      checks++; if (err_cnt - err0 != 1 || ov_cnt != ov0) begin
         errors++; $display("FAIL mismatch_counts got=err%0d ov%0d want=err1 ov0", err_cnt - err0, ov_cnt - ov0); end
   endtask

   task automatic test_illegal_header();
      int err0, wr0;
      #1; err0 = err_cnt; wr0 = wr_cnt;
      @(negedge clk);
      timed_out = 1'b0;
      send_byte(8'h50, 1'b0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b want=1", err); end
      @(negedge clk);
      checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL illegal_recover got=err%b rdy%b want=err0 rdy1", err, in_ready); end
      #1;
      checks++; if (wr_cnt != wr0 || err_cnt - err0 != 1) begin
         errors++; $display("FAIL illegal_counts got=wr%0d err%0d want=wr0 err1", wr_cnt - wr0, err_cnt - err0); end
   endtask

   task automatic test_reset_mid_job();
      int err0, ov0;
      timed_out = 1'b0;
      send_byte(8'h22, 1'b0);
      for (int n = 0; n < 4; n++) send_byte(8'(rnd_byte()), 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'(rnd_byte()), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL midreset_state got=rdy%b ov%b err%b want=rdy1 ov0 err0", in_ready, out_valid, err); end
      reset = 1'b0;
      @(negedge clk);
      #1; err0 = err_cnt; ov0 = ov_cnt;
      @(negedge clk);
      ma[0][0] = -3; mb[0][0] = 7;
      run_job(1, 1, 1, 1, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (obs_d.size() != 1 || timed_out) begin
         errors++; $display("FAIL midreset_count got=%0d timeout=%b want=1", obs_d.size(), timed_out); end
      else begin
         checks++; if (obs_d[0] !== OW'(-21) || obs_l[0] !== 1'b1) begin
            errors++; $display("FAIL midreset_data got=%0d/last%b want=-21/last1", $signed(obs_d[0]), obs_l[0]); end
      end
      checks++; if (ov_cnt - ov0 != 1 || err_cnt != err0) begin
         errors++; $display("FAIL midreset_counts got=ov%0d err%0d want=ov1 err0", ov_cnt - ov0, err_cnt - err0); end
   endtask

   task automatic test_back_to_back();
      int dims [2] = '{4, 2};
      foreach (dims[t]) begin
         int d = dims[t];
         for (int r = 0; r < d; r++)
            for (int c = 0; c < d; c++) begin ma[r][c] = rnd_byte(); mb[r][c] = rnd_byte(); end
         run_job(d, d, d, d, 0, 0, 1'b0);
         checks++; if (obs_d.size() != d * d || timed_out) begin
            errors++; $display("FAIL b2b%0d_count got=%0d timeout=%b want=%0d", d, obs_d.size(), timed_out, d * d); end
         for (int n = 0; n < obs_d.size() && n < d * d; n++) begin
            logic [OW-1:0] e = ref_elem(n / d, n % d, d);
            checks++; if (obs_d[n] !== e || obs_l[n] !== (n == d * d - 1)) begin
               errors++; $display("FAIL b2b%0d_elem%0d got=%0d/last%b want=%0d/last%b", d, n,
                                  $signed(obs_d[n]), obs_l[n], $signed(e), n == d * d - 1); end
         end
      end
   endtask

   task automatic test_random_jobs();
      for (int t = 0; t < 6; t++) begin
         int ra = int'($urandom_range(1, 4));
         int k  = int'($urandom_range(1, 4));
         int cb = int'($urandom_range(1, 4));
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin ma[r][c] = rnd_byte(); mb[r][c] = rnd_byte(); end
         run_job(ra, k, k, cb, 0, 3, 1'b1);
         checks++; if (obs_d.size() != ra * cb || timed_out || unstable != 0) begin
            errors++; $display("FAIL rand%0d_count got=%0d timeout=%b unstable=%0d want=%0d", t,
                               obs_d.size(), timed_out, unstable, ra * cb); end
         for (int n = 0; n < obs_d.size() && n < ra * cb; n++) begin
            logic [OW-1:0] e = ref_elem(n / cb, n % cb, k);
            checks++; if (obs_d[n] !== e || obs_l[n] !== (n == ra * cb - 1)) begin
               errors++; $display("FAIL rand%0d_elem%0d got=%0d/last%b want=%0d/last%b", t, n,
                                  $signed(obs_d[n]), obs_l[n], $signed(e), n == ra * cb - 1); end
         end
      end
   endtask

   task automatic test_strobes();
      #1;
      checks++; if (overlap_cnt != 0) begin
         errors++; $display("FAIL strobe_overlap got=%0d cycles want=0", overlap_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_mismatch();
      test_illegal_header();
      test_reset_mid_job();
      test_back_to_back();
      test_random_jobs();
      test_strobes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
